// File: rtl/scl_generate_if.sv
// Bundle of signals between the I2C master FSM and the SCL timing generator.
// The master drives the state and counter clears; the generator returns SCL and the bit-timing strobes.
interface scl_generate_if;
    logic [3:0] state_master;
    logic       rst_count;
    logic       rst_count_2;
    logic       scl_in;
    logic       scl;
    logic [6:0] count_ctrl;
    logic [3:0] count;
    logic       wait_for_sync;
    logic       add_sent;
    logic       data_sent;
    logic       data_received;
    logic       stretching;

    modport master (
        output state_master, rst_count, rst_count_2, scl_in,
        input  scl, count_ctrl, count, wait_for_sync, add_sent,
               data_sent, data_received, stretching
    );

    modport slave (
        input  state_master, rst_count, rst_count_2, scl_in,
        output scl, count_ctrl, count, wait_for_sync, add_sent,
               data_sent, data_received, stretching
    );
endinterface

// File: rtl/scl_generate.sv
// SCL waveform and bit-timing generator for an I2C master.
// It counts clk phases within each bit period, counts bits within a byte, and stalls while a slave stretches SCL.
module scl_generate #(
    parameter int T_LOW    = 6,
    parameter int T_HIGH   = 4,
    parameter int T_HD_STA = 4,
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8
) (
    input logic          clk,
    input logic          rst,
    scl_generate_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE           = 4'd0,
        ST_READY          = 4'd1,
        ST_SEND_ADDRESS   = 4'd2,
        ST_CHECK_ACK_ADDR = 4'd3,
        ST_WRITE_DATA     = 4'd4,
        ST_CHECK_ACK_DATA = 4'd5,
        ST_READ_DATA      = 4'd6,
        ST_SEND_ACK       = 4'd7,
        ST_STOP           = 4'd8
    } state_t;

    localparam int         PERIOD     = T_LOW + T_HIGH;
    localparam logic [6:0] PERIOD_M1  = 7'(PERIOD - 1);
    localparam logic [6:0] T_LOW_C    = 7'(T_LOW);
    localparam logic [6:0] T_HD_STA_C = 7'(T_HD_STA);
    localparam logic [3:0] ADDR_LAST  = 4'(ADDR_LEN);
    localparam logic [3:0] DATA_LAST  = 4'(DATA_LEN - 1);

    logic [6:0] count_ctrl_reg, count_ctrl_next;
    logic [3:0] count_reg, count_next;

    logic is_ready;
    logic is_active;
    logic is_idle;
    logic is_bit_state;
    logic high_phase;
    logic period_end;
    logic stall;

    always_comb begin
        is_ready     = (bus.state_master == ST_READY);
        is_active    = (bus.state_master >= ST_SEND_ADDRESS) && (bus.state_master <= ST_STOP);
        is_idle      = !(is_ready || is_active);
        is_bit_state = (bus.state_master == ST_SEND_ADDRESS) ||
                       (bus.state_master == ST_WRITE_DATA)   ||
                       (bus.state_master == ST_READ_DATA);
        high_phase   = (count_ctrl_reg >= T_LOW_C);
        period_end   = (count_ctrl_reg >= PERIOD_M1);
        // A slave holding SCL low during our high phase freezes the bit timing.
        stall        = is_active && high_phase && !bus.scl_in;
    end

    always_comb begin
        count_ctrl_next = count_ctrl_reg;
        count_next      = count_reg;
        if (bus.rst_count || is_idle) begin
            count_ctrl_next = '0;
            count_next      = '0;
        end else begin
            if (!stall) begin
                if (period_end) begin
                    count_ctrl_next = '0;
                    count_next      = count_reg + 4'd1;
                end else begin
                    count_ctrl_next = count_ctrl_reg + 7'd1;
                end
            end
            if (bus.rst_count_2 || !is_bit_state) begin
                count_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_ctrl_reg <= '0;
            count_reg      <= '0;
        end else begin
            count_ctrl_reg <= count_ctrl_next;
            count_reg      <= count_next;
        end
    end

    // Strobes decode the registered counters directly so the master sees them in the same cycle.
    always_comb begin
        if (is_ready) begin
            bus.scl = (count_ctrl_reg < T_HD_STA_C);
        end else if (is_active) begin
            bus.scl = high_phase;
        end else begin
            bus.scl = 1'b1;
        end
        bus.count_ctrl    = count_ctrl_reg;
        bus.count         = count_reg;
        bus.stretching    = stall;
        bus.wait_for_sync = is_ready && (count_ctrl_reg == PERIOD_M1);
        bus.add_sent      = (bus.state_master == ST_SEND_ADDRESS) && (count_reg == ADDR_LAST) &&
                            (count_ctrl_reg == PERIOD_M1) && bus.scl_in;
        bus.data_sent     = (bus.state_master == ST_WRITE_DATA) && (count_reg == DATA_LAST) &&
                            (count_ctrl_reg == PERIOD_M1) && bus.scl_in;
        bus.data_received = (bus.state_master == ST_READ_DATA) && (count_reg == DATA_LAST) &&
                            (count_ctrl_reg == PERIOD_M1) && bus.scl_in;
    end
endmodule

// File: doc/scl_generate.md
SCL_GENERATE -- requirements
Module: scl_generate

Interface
REQ-001 Parameter T_LOW, default 6: SCL-low clk cycles per bit period.
REQ-002 Parameter T_HIGH, default 4: SCL-high clk cycles per bit period.
REQ-003 Parameter T_HD_STA, default 4: Ready-state cycles SCL stays high.
REQ-004 Parameter ADDR_LEN, default 7: address bits; address phase is ADDR_LEN+1 bits including R/W.
REQ-005 Parameter DATA_LEN, default 8: data bits per byte.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 state_master  input  4  master FSM state: Idle=0, Ready=1, Send_Address=2, Check_ACK_addr=3, Write_Data=4, Check_ACK_data=5, Read_Data=6, Send_ACK=7, Stop=8.
REQ-009 rst_count  input  1  clear count_ctrl and count on next edge.
REQ-010 rst_count_2  input  1  clear count on next edge.
REQ-011 scl_in  input  1  SCL bus line readback, for clock-stretch detection.
REQ-012 scl  output  1  SCL drive level; 1 = released, 0 = pull low.
REQ-013 count_ctrl  output  7  phase counter within the bit period.
REQ-014 count  output  4  bit index within the current byte/address.
REQ-015 wait_for_sync  output  1  one-cycle pulse: START condition complete.
REQ-016 add_sent  output  1  one-cycle pulse: final address/R-W bit period complete.
REQ-017 data_sent  output  1  one-cycle pulse: final written data bit period complete.
REQ-018 data_received  output  1  one-cycle pulse: final read data bit period complete.
REQ-019 stretching  output  1  high while a slave holds SCL low in the high phase.

Function
REQ-020 P = T_LOW+T_HIGH; legal parameters: P <= 127, T_HD_STA < P, T_LOW >= 2.
REQ-021 Counters: rst_count=1 -> count_ctrl<=0, count<=0 (priority over all other updates).
REQ-022 rst_count_2=1 (rst_count=0) -> count<=0; count_ctrl advances normally.
REQ-023 state Idle -> count_ctrl and count held at 0.
REQ-024 Other states: count_ctrl increments by 1 per clk; at P-1 wraps to 0; never exceeds P-1.
REQ-025 On wrap in Send_Address, Write_Data or Read_Data, count increments (4-bit, no saturation needed); in every other state count holds 0.
REQ-026 Stretch: stall = (state in 2..8) & (count_ctrl >= T_LOW) & (scl_in == 0); stall -> count_ctrl and count hold, stretching=1.
REQ-027 scl decode, function of state_master and count_ctrl only: Idle -> 1; Ready -> 1 if count_ctrl < T_HD_STA else 0; states 2..8 -> 0 if count_ctrl < T_LOW else 1.
REQ-028 wait_for_sync = (state==Ready) & (count_ctrl==P-1); no stretch gating.
REQ-029 add_sent = (state==Send_Address) & (count==ADDR_LEN) & (count_ctrl==P-1) & scl_in.
REQ-030 data_sent = (state==Write_Data) & (count==DATA_LEN-1) & (count_ctrl==P-1) & scl_in.
REQ-031 data_received = (state==Read_Data) & (count==DATA_LEN-1) & (count_ctrl==P-1) & scl_in.
REQ-032 All strobes are combinational decodes of registered counters; zero latency so the master sees them in the same cycle; each lasts exactly one clk.
REQ-033 ACK states (3, 5, 7) and Stop produce no strobe; the master transitions on count_ctrl==P-1, and the natural wrap gives count_ctrl=0 in the next state.
REQ-034 Illegal state_master (9..15) is treated as Idle for scl and counters.
REQ-035 Simultaneous rst_count and stall -> rst_count wins.

Reset
REQ-036 rst=1 at an edge -> count_ctrl=0, count=0; outputs scl=1, all strobes 0, stretching=0; takes effect mid-transfer regardless of state_master.
REQ-037 First post-reset edge with rst=0 follows REQ-021..REQ-027 normally.

Verification
REQ-038 Reset mid Write_Data (count=3, count_ctrl=7) -> next cycle count=0, count_ctrl=0, scl=1 with state Idle.
REQ-039 Ready from count_ctrl=0 -> scl=1 for 4 cycles, 0 for 6; wait_for_sync high only at count_ctrl=9; rst_count -> count_ctrl=0.
REQ-040 Send_Address, no stretch -> 8 periods of 10 clk (scl low 6, high 4); add_sent single pulse at count=7, count_ctrl=9.
REQ-041 Write_Data, scl_in forced low for 5 clk at count_ctrl=6 -> count_ctrl holds 6, stretching=1 for 5 clk, then resumes; data_sent delayed by 5 clk.
REQ-042 Check_ACK_addr -> Write_Data at wrap -> count stays 0 throughout ACK and starts at 0 in Write_Data.
REQ-043 Read_Data, scl_in low at count_ctrl=9, count=7 -> data_received suppressed until scl_in=1.
